// File: rtl/led_p2s_serializer.sv
// ============================================================================
// led_p2s_serializer
//
// Parallel-to-serial driver for 74HC595-style LED / segment shift-register
// chains. A rising edge on `start` captures a WIDTH-bit word, which is then
// shifted out on `sdat` together with a generated serial clock `sclk`. Each
// frame ends with a latch strobe on `slatch`, followed by a single-cycle
// `done` pulse.
//
// Frame timeline, counted in system clocks from the load edge:
//   SHIFT : WIDTH bits. Each bit is sclk low for DIV cycles, then high for
//           DIV cycles. sdat changes only at bit boundaries, when sclk is low.
//   LATCH : DIV cycles with slatch high and both sclk and sdat low.
//   DONE  : one cycle with done high.
//   The done cycle falls 2*DIV*WIDTH + DIV cycles after the load edge.
//
// Parameters:
//   WIDTH     bits per frame (2..64)
//   DIV       system clocks per sclk half-period (>= 1)
//   LSB_FIRST 1: bit 0 is shifted first, 0: bit WIDTH-1 is shifted first
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst     in   1      synchronous reset, active-low
//   start   in   1      level input; its rising edge requests a frame
//   p_in    in   WIDTH  parallel data, sampled only at frame load
//   sdat    out  1      serial data
//   sclk    out  1      serial clock (the chain samples on its rising edge)
//   slatch  out  1      latch/store strobe, active-high
//   busy    out  1      high while a frame is in progress
//   done    out  1      one-cycle pulse at frame completion
// ============================================================================
module led_p2s_serializer #(
    parameter int WIDTH     = 16,
    parameter int DIV       = 2,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] p_in,
    output logic             sdat,
    output logic             sclk,
    output logic             slatch,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic               phase_q, phase_d;   // 0: sclk-low half, 1: sclk-high half
    logic               start_q;

    logic               sdat_q,   sdat_d;
    logic               sclk_q,   sclk_d;
    logic               slatch_q, slatch_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic               req;

    // Bit presented to the chain: the end of the register nearest the output.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // Advance one place toward the output; the vacated position fills with 0.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign req = start & ~start_q;

    // ------------------------------------------------------------------
    // Next-state and output decode. Outputs are computed for the state
    // being entered and then registered, so the board pins come straight
    // from flops and cannot glitch.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        sdat_d   = 1'b0;
        sclk_d   = 1'b0;
        slatch_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_SHIFT;
                    shreg_d = p_in;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                    sdat_d  = out_bit(p_in);
                end
            end

            S_SHIFT: begin
                busy_d = 1'b1;
                if (div_q != DIV_LAST) begin
                    // Inside a half-period: hold both lines.
                    div_d  = div_q + 1'b1;
                    sclk_d = phase_q;
                    sdat_d = out_bit(shreg_q);
                end else if (!phase_q) begin
                    // Low half complete: raise sclk, data unchanged.
                    div_d   = '0;
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                    sdat_d  = out_bit(shreg_q);
                end else if (bit_q == BIT_LAST) begin
                    // High half of the final bit complete.
                    div_d    = '0;
                    bit_d    = '0;
                    phase_d  = 1'b0;
                    state_d  = S_LATCH;
                    slatch_d = 1'b1;
                end else begin
                    // Bit boundary: drop sclk and present the next bit.
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = bit_q + 1'b1;
                    shreg_d = shift_once(shreg_q);
                    sdat_d  = out_bit(shift_once(shreg_q));
                end
            end

            S_LATCH: begin
                if (div_q != DIV_LAST) begin
                    div_d    = div_q + 1'b1;
                    slatch_d = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    div_d   = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_DONE: begin
                // Requests arriving here are dropped, not queued.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and output registers. Clearing start_q in reset
    // makes a start held high through reset release look like a fresh
    // rising edge, producing exactly one frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            start_q  <= 1'b0;
            sdat_q   <= 1'b0;
            sclk_q   <= 1'b0;
            slatch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            start_q  <= start;
            sdat_q   <= sdat_d;
            sclk_q   <= sclk_d;
            slatch_q <= slatch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sdat   = sdat_q;
    assign sclk   = sclk_q;
    assign slatch = slatch_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_led_p2s_serializer.sv
// ============================================================================
// tb_led_p2s_serializer
//
// Three instances run side by side on one clock:
//   u0: WIDTH=16, DIV=2, LSB first (defaults)
//   u1: WIDTH=8,  DIV=1, MSB first
//   u2: WIDTH=32, DIV=3, LSB first
// A frame-timeline reference model predicts every output of every instance
// on every cycle. Directed scenarios are followed by randomized traffic.
// ============================================================================
module tb_led_p2s_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  st;
    logic [15:0] p0;
    logic [7:0]  p1;
    logic [31:0] p2;
    logic [2:0]  sdat_w, sclk_w, slatch_w, busy_w, done_w;

    always #5 clk = ~clk;

    led_p2s_serializer #(.WIDTH(16), .DIV(2), .LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .p_in(p0),
        .sdat(sdat_w[0]), .sclk(sclk_w[0]), .slatch(slatch_w[0]),
        .busy(busy_w[0]), .done(done_w[0]));

    led_p2s_serializer #(.WIDTH(8), .DIV(1), .LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .p_in(p1),
        .sdat(sdat_w[1]), .sclk(sclk_w[1]), .slatch(slatch_w[1]),
        .busy(busy_w[1]), .done(done_w[1]));

    led_p2s_serializer #(.WIDTH(32), .DIV(3), .LSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .p_in(p2),
        .sdat(sdat_w[2]), .sclk(sclk_w[2]), .slatch(slatch_w[2]),
        .busy(busy_w[2]), .done(done_w[2]));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: a frame is a timeline indexed by k, the number of
    // edges since the load edge.
    logic [63:0] m_word [3];
    int          m_k    [3];
    bit          m_act  [3];
    bit          m_sprev[3];
    logic [4:0]  m_exp  [3];

    // Per-instance statistics for the directed scenarios.
    int          n_done[3], n_slatch[3], n_busy[3], n_rise[3];
    int          load_cyc[3], done_cyc[3], cap_n[3];
    logic [63:0] cap_word[3];
    logic        prev_sclk[3], prev_busy[3];

    function automatic int pw(input int d);
        case (d) 0: return 16; 1: return 8; default: return 32; endcase
    endfunction

    function automatic int pd(input int d);
        case (d) 0: return 2; 1: return 1; default: return 3; endcase
    endfunction

    function automatic bit pl(input int d);
        case (d) 0: return 1'b1; 1: return 1'b0; default: return 1'b1; endcase
    endfunction

    function automatic logic [63:0] getp(input int d);
        case (d)
            0:       return {48'b0, p0};
            1:       return {56'b0, p1};
            default: return {32'b0, p2};
        endcase
    endfunction

    function automatic logic [4:0] getout(input int d);
        return {sdat_w[d], sclk_w[d], slatch_w[d], busy_w[d], done_w[d]};
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs about to be
    // sampled, and compute the outputs expected after that edge.
    task automatic model_edge(input int d);
        int W, D, L, b;
        bit req, bv, sc;
        W = pw(d);
        D = pd(d);
        L = 2 * D * W + D;
        if (!rst) begin
            m_act[d]   = 1'b0;
            m_sprev[d] = 1'b0;
        end else begin
            req        = st[d] && !m_sprev[d];
            m_sprev[d] = st[d];
            if (m_act[d]) begin
                m_k[d]++;
                if (m_k[d] > L) m_act[d] = 1'b0;   // leaving the done cycle; requests dropped
            end else if (req) begin
                m_act[d]  = 1'b1;
                m_k[d]    = 0;
                m_word[d] = getp(d);
            end
        end
        if (!m_act[d]) begin
            m_exp[d] = 5'b00000;
        end else if (m_k[d] < 2 * D * W) begin
            b  = m_k[d] / (2 * D);
            bv = pl(d) ? m_word[d][b] : m_word[d][W - 1 - b];
            sc = (m_k[d] % (2 * D)) >= D;
            m_exp[d] = {bv, sc, 1'b0, 1'b1, 1'b0};
        end else if (m_k[d] < L) begin
            m_exp[d] = 5'b00110;
        end else begin
            m_exp[d] = 5'b00001;
        end
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 3; d++) begin
            n_done[d]   = 0;
            n_slatch[d] = 0;
            n_busy[d]   = 0;
            n_rise[d]   = 0;
            load_cyc[d] = 0;
            done_cyc[d] = 0;
            cap_n[d]    = 0;
            cap_word[d] = '0;
        end
    endtask

    task automatic step();
        int idx;
        for (int d = 0; d < 3; d++) model_edge(d);
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            chk_eq($sformatf("cyc%0d_u%0d_outs", cyc, d), {59'b0, getout(d)}, {59'b0, m_exp[d]});
            if (done_w[d]) begin
                n_done[d]++;
                done_cyc[d] = cyc;
            end
            if (slatch_w[d]) n_slatch[d]++;
            if (busy_w[d]) n_busy[d]++;
            if (busy_w[d] && !prev_busy[d]) load_cyc[d] = cyc;
            if (sclk_w[d] && !prev_sclk[d]) begin
                n_rise[d]++;
                if (cap_n[d] < pw(d)) begin
                    idx = pl(d) ? cap_n[d] : pw(d) - 1 - cap_n[d];
                    cap_word[d][idx] = sdat_w[d];
                    cap_n[d]++;
                end
            end
            prev_sclk[d] = sclk_w[d];
            prev_busy[d] = busy_w[d];
        end
        #3;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_word[d] = '0; m_k[d] = 0; m_act[d] = 1'b0; m_sprev[d] = 1'b0;
            m_exp[d] = '0; prev_sclk[d] = 1'b0; prev_busy[d] = 1'b0;
        end
        clr_stats();
        rst = 1'b0;
        st  = 3'b000;
        p0  = '0;
        p1  = '0;
        p2  = '0;
        #2;

        // Reset state
        repeat (3) step();
        chk_eq("reset_outs", {49'b0, sdat_w, sclk_w, slatch_w, busy_w, done_w}, 64'd0);
        rst = 1'b1;
        repeat (2) step();

        // Default instance, A5C3, single start pulse
        clr_stats();
        p0 = 16'hA5C3; st[0] = 1'b1; step(); st[0] = 1'b0;
        repeat (79) step();
        chk_eq("t1_bits",    cap_word[0], 64'hA5C3);
        chk_eq("t1_done_n",  64'(n_done[0]), 64'd1);
        chk_eq("t1_latency", 64'(done_cyc[0] - load_cyc[0]), 64'd66);
        chk_eq("t1_busy_n",  64'(n_busy[0]), 64'd66);
        chk_eq("t1_slatch",  64'(n_slatch[0]), 64'd2);

        // MSB first, WIDTH=8, DIV=1
        clr_stats();
        p1 = 8'h81; st[1] = 1'b1; step(); st[1] = 1'b0;
        repeat (24) step();
        chk_eq("t2_bits",    cap_word[1], 64'h81);
        chk_eq("t2_latency", 64'(done_cyc[1] - load_cyc[1]), 64'd17);
        chk_eq("t2_rises",   64'(n_rise[1]), 64'd8);
        chk_eq("t2_done_n",  64'(n_done[1]), 64'd1);

        // start held high, p_in changed mid-frame
        clr_stats();
        p0 = 16'h3C5A; st[0] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i == 20) p0 = 16'hFFFF;
            step();
        end
        st[0] = 1'b0;
        repeat (5) step();
        chk_eq("t3_done_n", 64'(n_done[0]), 64'd1);
        chk_eq("t3_bits",   cap_word[0], 64'h3C5A);

        // Requests mid-frame and in the done cycle are dropped
        clr_stats();
        p0 = 16'h1F2E; st[0] = 1'b1; step(); st[0] = 1'b0;
        repeat (19) step();
        st[0] = 1'b1; step(); st[0] = 1'b0;
        repeat (46) step();
        chk_eq("t4_done_cycle", 64'(done_w[0]), 64'd1);
        st[0] = 1'b1; step(); st[0] = 1'b0;
        chk_eq("t4_done_n1", 64'(n_done[0]), 64'd1);
        chk_eq("t4_idle",    64'(busy_w[0]), 64'd0);
        step();
        st[0] = 1'b1; step(); st[0] = 1'b0;
        repeat (75) step();
        chk_eq("t4_bits",    cap_word[0], 64'h1F2E);
        chk_eq("t4_done_n2", 64'(n_done[0]), 64'd2);

        // Reset during bit 7, then start held through release
        clr_stats();
        p0 = 16'h00FF; st[0] = 1'b1; step(); st[0] = 1'b0;
        repeat (29) step();
        rst = 1'b0; st[0] = 1'b1; step();
        chk_eq("t5_rst_outs", {59'b0, getout(0)}, 64'd0);
        repeat (2) step();
        rst = 1'b1;
        repeat (80) step();
        st[0] = 1'b0; step();
        chk_eq("t5_done_n",  64'(n_done[0]), 64'd1);
        chk_eq("t5_slatch",  64'(n_slatch[0]), 64'd2);
        chk_eq("t5_latency", 64'(done_cyc[0] - load_cyc[0]), 64'd66);

        // WIDTH=32, DIV=3
        clr_stats();
        p2 = 32'h8000_0001; st[2] = 1'b1; step(); st[2] = 1'b0;
        repeat (200) step();
        chk_eq("t6_bits",    cap_word[2], 64'h8000_0001);
        chk_eq("t6_latency", 64'(done_cyc[2] - load_cyc[2]), 64'd195);
        chk_eq("t6_done_n",  64'(n_done[2]), 64'd1);

        // Randomized traffic: start toggles, p_in churn, occasional reset
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 3; d++)
                if ($urandom_range(0, 5) == 0) st[d] = ~st[d];
            p0  = 16'($urandom);
            p1  = 8'($urandom);
            p2  = $urandom;
            rst = ($urandom_range(0, 499) != 0);
            step();
        end
        rst = 1'b1;
        st  = 3'b000;
        repeat (220) step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/led_p2s_serializer.md
Name: led_p2s_serializer

Overview:
- Parametrised parallel-to-serial driver for serial-in LED/segment shift-register chains (74HC595-style).
- Captures a WIDTH-bit word on a rising edge of `start` and shifts it out on `sdat`, with a generated serial clock `sclk`.
- Ends each frame with a latch strobe on `slatch`, then pulses `done`.
- Sits between the display-data logic and the board's serial LED pins, replacing the fixed 16-bit shift register.

Parameters:
- WIDTH, 16, bits per frame (legal: 2..64).
- DIV, 2, system clocks per sclk half-period (legal: >=1).
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 first.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on clk rising edge.
- start  input  1  level input; its rising edge requests a frame.
- p_in  input  WIDTH  parallel data, sampled only at frame load.
- sdat  output  1  serial data.
- sclk  output  1  serial clock; the chain samples on its rising edge.
- slatch  output  1  latch/store strobe, active-high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0 at a clk edge):
  - sdat=0, sclk=0, slatch=0, busy=0, done=0; state=IDLE; all counters=0.
  - The start history register is cleared to 0. A start held high through reset release therefore produces exactly one frame.
- Edge detect:
  - start_q <= start every cycle, except during reset.
  - Request = start & ~start_q.
  - A request outside IDLE is dropped, not queued. This includes requests during LATCH and DONE.
- States: IDLE -> SHIFT -> LATCH -> DONE -> IDLE.
- IDLE:
  - Outputs low.
  - On the edge where a request is seen, load the shift register with p_in and go to SHIFT.
  - From that edge: busy=1 and sdat = first bit (p_in[0] if LSB_FIRST, else p_in[WIDTH-1]).
- SHIFT:
  - Each bit occupies 2*DIV cycles: sclk=0 for DIV cycles, then sclk=1 for DIV cycles.
  - sdat is stable for the whole bit period, so sdat changes only while sclk is low (at the bit boundary).
  - At the end of each bit the register shifts one place toward the output. The vacated position fills with 0.
  - The bit counter counts 0..WIDTH-1. After the high phase of bit WIDTH-1, go to LATCH.
- LATCH:
  - sclk=0, sdat=0, slatch=1 for DIV cycles, then go to DONE.
- DONE:
  - One cycle: done=1, busy=0, slatch=0, then IDLE.
  - A request seen in this cycle is dropped.
- Latency: from the load edge to the done cycle is 2*DIV*WIDTH + DIV cycles. Default: 66 cycles.
- Minimum request spacing between accepted frames: 2*DIV*WIDTH + DIV + 2 cycles.
- p_in changes after load do not affect the frame in flight.
- Reset mid-frame: all outputs drop on the next edge. No latch strobe or done pulse is emitted, and the partial frame is abandoned.
- Counters are sized $clog2(DIV) and $clog2(WIDTH), with a minimum of 1 bit. Counters never wrap inside a state.

Test Plan:
1. Default parameters, p_in=16'hA5C3, one start pulse.
   - At 16 sclk rising edges, sdat reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first).
   - slatch is high for 2 cycles.
   - done pulses exactly 66 cycles after the load edge; busy is high for 66 cycles.
2. LSB_FIRST=0, WIDTH=8, DIV=1, p_in=8'h81.
   - Bits out: 1,0,0,0,0,0,0,1.
   - sclk toggles every cycle.
   - done arrives 17 cycles after load.
3. start held high for 200 cycles.
   - Exactly one frame and one done pulse.
   - Change p_in to 16'hFFFF mid-frame: the serial output is still the original word.
4. Second start edge at cycle 20 of a frame, then another in the DONE cycle.
   - Both are ignored; no second frame.
   - A new edge 2 cycles after done starts a new frame.
5. rst=0 asserted during bit 7.
   - On the next edge all outputs are 0 and no slatch/done is emitted.
   - After release with start=1 held, one fresh frame runs.
6. WIDTH=32, DIV=3, p_in=32'h8000_0001, LSB first.
   - First and last bits are 1, the rest 0.
   - done arrives 195 cycles after load.
